// File: rtl/mem_router_pkg.sv
// mem_router_pkg: shared types, default address map and error pattern for mem_router
package mem_router_pkg;
  localparam int XLEN = 64;
  localparam int DEF_NTGT = 2;
  localparam int IDX_W = $clog2(DEF_NTGT);
  typedef logic [XLEN-1:0] xlen_t;
  typedef struct packed {
    logic err;
    logic [IDX_W-1:0] idx;
  } tag_t;
  // index 0 is the UART, index 1 is main memory
  localparam xlen_t DEF_BASE [DEF_NTGT] = '{64'h1000_0000, 64'h8000_0000};
  localparam xlen_t DEF_END [DEF_NTGT] = '{64'h1000_0100, 64'h8010_0000};
  localparam xlen_t ERR_DATA = 64'hbada_bada_bada_bada;
endpackage

// File: rtl/mem_router_tag_fifo.sv
// tag_fifo: synchronous FIFO with registered pointers and combinational head
module tag_fifo #(
  parameter int W = 2,
  parameter int D = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(D);
  logic [W-1:0] mem [D];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0] cnt;
  logic wr, rd;
  assign full = cnt == (AW+1)'(D);
  assign empty = cnt == '0;
  assign wr = push & ~full;
  assign rd = pop & ~empty;
  assign head = mem[rptr];
  always_ff @(posedge clk) if (wr) mem[wptr] <= din;
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt <= '0;
    end else begin
      wptr <= wptr + AW'(wr);
      rptr <= rptr + AW'(rd);
      cnt <= cnt + (AW+1)'(wr) - (AW+1)'(rd);
    end
  end
endmodule

// File: rtl/mem_router.sv
// mem_router: decodes core loads/stores onto memory-mapped targets, returning load data in request order
module mem_router import mem_router_pkg::*; #(
  parameter int    NTGT = DEF_NTGT,
  parameter int    MAX_OUTST = 4,
  parameter xlen_t TGT_BASE [NTGT] = DEF_BASE,
  parameter xlen_t TGT_END [NTGT] = DEF_END
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ld_a_valid,
  output logic        ld_a_ready,
  input  xlen_t       ld_a_addr,
  output logic        ld_d_valid,
  output xlen_t       ld_d_data,
  output logic        ld_d_err,
  input  logic        st_valid,
  output logic        st_ready,
  input  xlen_t       st_addr,
  input  xlen_t       st_data,
  input  logic [7:0]  st_mask,
  output logic        st_err,
  output logic        t_ld_a_valid [NTGT],
  input  logic        t_ld_a_ready [NTGT],
  output xlen_t       t_ld_a_addr [NTGT],
  input  logic        t_ld_d_valid [NTGT],
  output logic        t_ld_d_ready [NTGT],
  input  xlen_t       t_ld_d_data [NTGT],
  output logic        t_st_valid [NTGT],
  input  logic        t_st_ready [NTGT],
  output xlen_t       t_st_addr [NTGT],
  output xlen_t       t_st_data,
  output logic [7:0]  t_st_mask
);
  logic [IDX_W-1:0] ld_sel, st_sel;
  logic ld_hit, st_hit, full, empty, push, pop;
  tag_t head, tag_in;
  // scanning downwards lets the lowest matching index win on overlaps
  always_comb begin
    ld_sel = '0;
    ld_hit = 1'b0;
    st_sel = '0;
    st_hit = 1'b0;
    for (int i = NTGT - 1; i >= 0; i--) begin
      if (ld_a_addr >= TGT_BASE[i] && ld_a_addr < TGT_END[i]) begin
        ld_hit = 1'b1;
        ld_sel = IDX_W'(i);
      end
      if (st_addr >= TGT_BASE[i] && st_addr < TGT_END[i]) begin
        st_hit = 1'b1;
        st_sel = IDX_W'(i);
      end
    end
  end
  always_comb begin
    for (int i = 0; i < NTGT; i++) begin
      t_ld_a_valid[i] = ld_a_valid & ld_hit & (ld_sel == IDX_W'(i)) & ~full;
      t_ld_a_addr[i] = ld_a_addr - TGT_BASE[i];
      t_ld_d_ready[i] = ~empty & ~head.err & (head.idx == IDX_W'(i));
      t_st_valid[i] = st_valid & st_hit & (st_sel == IDX_W'(i));
      t_st_addr[i] = st_addr - TGT_BASE[i];
    end
  end
  assign ld_a_ready = ~full & (~ld_hit | t_ld_a_ready[ld_sel]);
  assign push = ld_a_valid & ld_a_ready;
  assign pop = ~empty & (head.err | t_ld_d_valid[head.idx]);
  assign tag_in = '{err: ~ld_hit, idx: ld_sel};
  assign st_ready = ~st_hit | t_st_ready[st_sel];
  assign t_st_data = st_data;
  assign t_st_mask = st_mask;
  tag_fifo #(.W($bits(tag_t)), .D(MAX_OUTST)) u_tag_fifo (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .din(tag_in),
    .head(head), .full(full), .empty(empty)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      ld_d_valid <= 1'b0;
      ld_d_err <= 1'b0;
      ld_d_data <= '0;
      st_err <= 1'b0;
    end else begin
      ld_d_valid <= pop;
      ld_d_err <= pop & head.err;
      if (pop) ld_d_data <= head.err ? ERR_DATA : t_ld_d_data[head.idx];
      st_err <= st_valid & ~st_hit;
    end
  end
endmodule
